fetch_unit: RTL and testbench

//  Instruction-fetch stage wrapped around the PC register. Computes next_PC, drives Adv to the PC,

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC select, imem request, IF/ID latch and
// a one-entry hold buffer that absorbs a fetched word while decode stalls.
module fetch_unit #(
  parameter int unsigned       WORD_W       = 32,
  parameter logic [WORD_W-1:0] BUBBLE_INSTR = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] PC,
  input  logic              Halt,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_PC,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] next_PC,
  output logic              Adv,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc4,
  output logic              ifid_valid
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: BUBBLE_INSTR, pc4: '0};

  state_t            state, state_nxt;
  ifid_t             ifid_q, ifid_nxt;
  ifid_t             hold_q, hold_nxt;
  logic              valid_q, valid_nxt;
  logic              adv_raw;
  logic [WORD_W-1:0] pc4;

  assign pc4 = PC + WORD_W'(4);

  // Next-state, PC advance, imem request and IF/ID / buffer next values
  always_comb begin
    state_nxt = state;
    ifid_nxt  = ifid_q;
    valid_nxt = valid_q;
    hold_nxt  = hold_q;
    adv_raw   = 1'b0;
    iaddr     = PC;
    next_PC   = redirect_en ? redirect_PC : pc4;
    iREN      = (state == FETCH) && !Halt;

    if (Halt) begin
      state_nxt = HALTED;
      ifid_nxt  = BUBBLE;
      valid_nxt = 1'b0;
    end else if (state == HALTED) begin
      // Sticky stop: only reset leaves HALTED.
      state_nxt = HALTED;
    end else if (redirect_en) begin
      // Any word returned this cycle belongs to the squashed path.
      adv_raw   = 1'b1;
      ifid_nxt  = BUBBLE;
      valid_nxt = 1'b0;
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (ihit) begin
            adv_raw = 1'b1;
            if (stall) begin
              hold_nxt  = '{instr: iload, pc4: pc4};
              state_nxt = HOLD;
            end else begin
              ifid_nxt  = '{instr: iload, pc4: pc4};
              valid_nxt = 1'b1;
            end
          end else if (!stall) begin
            ifid_nxt  = BUBBLE;
            valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_nxt  = hold_q;
            valid_nxt = 1'b1;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  // PC register must not load while reset is asserted
  assign Adv = adv_raw & nRST;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= state_nxt;
  end

  // IF/ID latch and hold buffer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ifid_q  <= BUBBLE;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      ifid_q  <= ifid_nxt;
      valid_q <= valid_nxt;
      hold_q  <= hold_nxt;
    end
  end

  assign ifid_instr = ifid_q.instr;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus scoreboard of IF/ID results.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] PC = '0;
  logic        Halt = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_PC = '0;
  logic        ihit = 1'b0;
  logic [31:0] iload = '0;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] next_PC;
  logic        Adv;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  fetch_unit #(.WORD_W(32), .BUBBLE_INSTR(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .PC(PC), .Halt(Halt), .stall(stall),
    .redirect_en(redirect_en), .redirect_PC(redirect_PC), .ihit(ihit),
    .iload(iload), .iREN(iREN), .iaddr(iaddr), .next_PC(next_PC), .Adv(Adv),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        halt, stall, redir, ihit;
    logic [31:0] rpc, iload, pc;
    logic        e_adv, e_iren;
    logic [31:0] e_npc;
    logic        e_valid;
    logic [31:0] e_instr, e_pc4;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc4;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic h, logic s, logic r, logic ih, logic [31:0] rpc,
                              logic [31:0] ld, logic [31:0] pc, logic ea, logic ei,
                              logic [31:0] en, logic ev, logic [31:0] einst, logic [31:0] ep4);
    vec_t v;
    v.halt = h; v.stall = s; v.redir = r; v.ihit = ih; v.rpc = rpc; v.iload = ld; v.pc = pc;
    v.e_adv = ea; v.e_iren = ei; v.e_npc = en; v.e_valid = ev; v.e_instr = einst; v.e_pc4 = ep4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Compare the IF/ID latch against the oldest scoreboard entry
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard_empty actual=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".ifid_valid"}, 32'(ifid_valid), 32'(e.valid));
      chk({tag, ".ifid_instr"}, ifid_instr, e.instr);
      if (e.valid) chk({tag, ".ifid_pc4"}, ifid_pc4, e.pc4);
    end
  endtask

  // Drive one cycle (called just after a rising edge), check comb outputs mid-cycle
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    Halt = v.halt; stall = v.stall; redirect_en = v.redir; ihit = v.ihit;
    redirect_PC = v.rpc; iload = v.iload; PC = v.pc;
    @(negedge CLK);
    chk({tag, ".Adv"}, 32'(Adv), 32'(v.e_adv));
    chk({tag, ".iREN"}, 32'(iREN), 32'(v.e_iren));
    chk({tag, ".iaddr"}, iaddr, v.pc);
    chk({tag, ".next_PC"}, next_PC, v.e_npc);
    e.valid = v.e_valid; e.instr = v.e_instr; e.pc4 = v.e_pc4;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    pop_check(tag);
  endtask

  // Assert reset between edges and check the reset-time outputs
  task automatic pulse_reset(input string tag);
    nRST = 1'b0;
    Halt = 1'b0; stall = 1'b0; redirect_en = 1'b0; ihit = 1'b1; PC = 32'h0;
    #2;
    chk({tag, ".rst_Adv"}, 32'(Adv), 32'h0);
    chk({tag, ".rst_iREN"}, 32'(iREN), 32'h1);
    chk({tag, ".rst_valid"}, 32'(ifid_valid), 32'h0);
    chk({tag, ".rst_instr"}, ifid_instr, 32'h0);
    chk({tag, ".rst_pc4"}, ifid_pc4, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line fetch
    vecs.push_back(mk(0,0,0,1,0,32'h20010001,32'h0,  1,1,32'h4, 1,32'h20010001,32'h4));
    vecs.push_back(mk(0,0,0,1,0,32'h20010002,32'h4,  1,1,32'h8, 1,32'h20010002,32'h8));
    vecs.push_back(mk(0,0,0,1,0,32'h20010003,32'h8,  1,1,32'hC, 1,32'h20010003,32'hC));
    // Stall on hit -> HOLD, two stall cycles, release
    vecs.push_back(mk(0,1,0,1,0,32'hAAAA0000,32'h10, 1,1,32'h14, 1,32'h20010003,32'hC));
    vecs.push_back(mk(0,1,0,1,0,32'hDEADBEEF,32'h14, 0,0,32'h18, 1,32'h20010003,32'hC));
    vecs.push_back(mk(0,1,0,1,0,32'hDEADBEEF,32'h14, 0,0,32'h18, 1,32'h20010003,32'hC));
    vecs.push_back(mk(0,0,0,1,0,32'hDEADBEEF,32'h14, 0,0,32'h18, 1,32'hAAAA0000,32'h14));
    vecs.push_back(mk(0,0,0,1,0,32'h11112222,32'h14, 1,1,32'h18, 1,32'h11112222,32'h18));
    // Stall with miss holds IF/ID
    vecs.push_back(mk(0,1,0,0,0,32'h0,32'h18,        0,1,32'h1C, 1,32'h11112222,32'h18));
    // Three misses at 0x40
    vecs.push_back(mk(0,0,0,0,0,32'h0,32'h40,        0,1,32'h44, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,32'h0,32'h40,        0,1,32'h44, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,32'h0,32'h40,        0,1,32'h44, 0,32'h0,32'h0));
    // Redirect beats ihit
    vecs.push_back(mk(0,0,1,1,32'h100,32'hCAFEF00D,32'h40, 1,1,32'h100, 0,32'h0,32'h0));
    // Enter HOLD, then redirect out of HOLD drops the buffer
    vecs.push_back(mk(0,1,0,1,0,32'h33334444,32'h100, 1,1,32'h104, 0,32'h0,32'h0));
    vecs.push_back(mk(0,1,1,1,32'h200,32'hDEADBEEF,32'h104, 1,0,32'h200, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,0,32'h55556666,32'h200, 1,1,32'h204, 1,32'h55556666,32'h204));
    // PC+4 wraps
    vecs.push_back(mk(0,0,0,1,0,32'h77778888,32'hFFFFFFFC, 1,1,32'h0, 1,32'h77778888,32'h0));
    // Halt is sticky
    vecs.push_back(mk(1,0,0,1,0,32'h12345678,32'h0, 0,0,32'h4, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,0,32'h12345678,32'h0, 0,0,32'h4, 0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,0,32'h12345678,32'h0, 0,0,32'h4, 0,32'h0,32'h0));

    @(posedge CLK);
    #1;
    pulse_reset("init");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset leaves HALTED and fetching resumes
    pulse_reset("unhalt");
    apply(mk(0,0,0,1,0,32'h99990000,32'h0, 1,1,32'h4, 1,32'h99990000,32'h4), "resume");

    // Reset while holding a word drops it
    apply(mk(0,1,0,1,0,32'hABCD0000,32'h4, 1,1,32'h8, 1,32'h99990000,32'h4), "hold_rst");
    pulse_reset("midhold");
    apply(mk(0,0,0,0,0,32'h0,32'h0, 0,1,32'h4, 0,32'h0,32'h0), "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
